// File: rtl/sfu_pkg.sv
// Shared types and default dimensions for the special-function / accumulation stage.
// The SFU_RELU_EN macro, when defined, clamps negative lanes to zero on drain
// (see sfu_lane_alu); the package itself is identical in both builds.
package sfu_pkg;

    // Job sequencing: wait for start, sum passes, stream results, pulse done.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sfu_state_t;

    // Default array geometry (lane count matches the mac_array columns).
    localparam int SFU_COL       = 8;
    localparam int SFU_PSUM_BW   = 16;
    localparam int SFU_ACC_DEPTH = 16;
    localparam int SFU_ADDR_BW   = 4;
    localparam int SFU_PASS_BW   = 4;

    // Lane adder and ReLU operate at the psum width; sums wrap, no widening.
    localparam int SFU_LANE_ADD_BW = SFU_PSUM_BW;
    localparam int SFU_RELU_BW     = SFU_PSUM_BW;

endpackage

// File: rtl/sfu_lane_alu.sv
// One psum lane: first-pass load or wrapping signed add for accumulation,
// plus the drain-side output function.
// Build option SFU_RELU_EN: defined -> negative lanes drain as zero;
// undefined -> raw signed psums drain unchanged.
module sfu_lane_alu
    import sfu_pkg::*;
#(
    parameter int psum_bw = SFU_LANE_ADD_BW
) (
    input  logic               first,
    input  logic [psum_bw-1:0] acc_in,
    input  logic [psum_bw-1:0] psum_in,
    input  logic [psum_bw-1:0] drain_in,
    output logic [psum_bw-1:0] acc_out,
    output logic [psum_bw-1:0] drain_out
);

    // First pass overwrites stale contents; later passes add with two's-complement wrap.
    always_comb begin
        acc_out = first ? psum_in : (acc_in + psum_in);
    end

    // Output function applied on the way to the output SRAM.
`ifdef SFU_RELU_EN
    always_comb begin
        drain_out = drain_in[psum_bw-1] ? '0 : drain_in;
    end
`else
    always_comb begin
        drain_out = drain_in;
    end
`endif

endmodule

// File: rtl/sfu_accum.sv
// Accumulation stage behind the corelet: pops psum rows from the OFIFO, sums
// them per output location over num_pass passes, then drains each location
// once through the lane output function. Build option SFU_RELU_EN selects
// ReLU on drain (see sfu_lane_alu).
module sfu_accum
    import sfu_pkg::*;
#(
    parameter int col       = SFU_COL,
    parameter int psum_bw   = SFU_PSUM_BW,
    parameter int acc_depth = SFU_ACC_DEPTH,
    parameter int addr_bw   = SFU_ADDR_BW,
    parameter int pass_bw   = SFU_PASS_BW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [pass_bw-1:0]     num_pass,
    input  logic                   ofifo_o_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [addr_bw-1:0]     out_addr,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   busy,
    output logic                   done
);

    localparam int                 ROW_BW    = col * psum_bw;
    localparam logic [addr_bw-1:0] LAST_ADDR = addr_bw'(acc_depth - 1);

    sfu_state_t          state_reg, state_next;
    logic [addr_bw-1:0]  addr_reg, addr_next;
    logic [pass_bw-1:0]  pass_reg, pass_next;
    logic [pass_bw-1:0]  num_pass_reg, num_pass_next;
    logic [ROW_BW-1:0]   out_data_reg;

    logic                pop;
    logic                load_out;
    logic [addr_bw-1:0]  addr_inc;
    logic [ROW_BW-1:0]   acc_rdata;
    logic [ROW_BW-1:0]   acc_wdata;
    logic [ROW_BW-1:0]   drain_rdata;
    logic [ROW_BW-1:0]   drain_f;

    logic [ROW_BW-1:0]   acc_mem [acc_depth];

    // Location counter wraps at the buffer depth, not at the counter width.
    always_comb begin
        addr_inc = (addr_reg == LAST_ADDR) ? '0 : (addr_reg + addr_bw'(1));
    end

    // Accumulate port reads the location being popped into; the drain port
    // reads the location that will be presented next cycle.
    always_comb begin
        acc_rdata   = acc_mem[addr_reg];
        drain_rdata = acc_mem[addr_next];
    end

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_lane
            sfu_lane_alu #(
                .psum_bw (psum_bw)
            ) u_lane (
                .first     (pass_reg == '0),
                .acc_in    (acc_rdata[gi*psum_bw +: psum_bw]),
                .psum_in   (ofifo_out[gi*psum_bw +: psum_bw]),
                .drain_in  (drain_rdata[gi*psum_bw +: psum_bw]),
                .acc_out   (acc_wdata[gi*psum_bw +: psum_bw]),
                .drain_out (drain_f[gi*psum_bw +: psum_bw])
            );
        end
    endgenerate

    // Next-state, counters and handshake decisions.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        pass_next     = pass_reg;
        num_pass_next = num_pass_reg;
        pop           = 1'b0;
        load_out      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = ACCUM;
                    num_pass_next = (num_pass == '0) ? pass_bw'(1) : num_pass;
                    addr_next     = '0;
                    pass_next     = '0;
                end
            end
            ACCUM: begin
                if (ofifo_o_valid) begin
                    pop       = 1'b1;
                    addr_next = addr_inc;
                    if (addr_reg == LAST_ADDR) begin
                        if (pass_reg == (num_pass_reg - pass_bw'(1))) begin
                            state_next = DRAIN;
                            pass_next  = '0;
                            load_out   = 1'b1;
                        end else begin
                            pass_next = pass_reg + pass_bw'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    addr_next = addr_inc;
                    if (addr_reg == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers and the registered drain data; reset abandons any job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            pass_reg     <= '0;
            num_pass_reg <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            pass_reg     <= pass_next;
            num_pass_reg <= num_pass_next;
            if (load_out) begin
                out_data_reg <= drain_f;
            end
        end
    end

    // Accumulator buffer; contents are meaningless until the first pass rewrites them.
    always_ff @(posedge clk) begin
        if (pop) begin
            acc_mem[addr_reg] <= acc_wdata;
        end
    end

    // Output decode straight from registered state.
    always_comb begin
        ofifo_rd  = pop;
        out_valid = (state_reg == DRAIN);
        out_addr  = (state_reg == DRAIN) ? addr_reg : '0;
        out_data  = out_data_reg;
        busy      = (state_reg != IDLE);
        done      = (state_reg == DONE);
    end

endmodule

// File: tb/tb_sfu_accum.sv
// Scoreboard bench for sfu_accum: stimulus pushes OFIFO rows and expected
// output writes; a monitor pops expectations on each accepted write.
module tb_sfu_accum;

    localparam int COL   = 8;
    localparam int PBW   = 16;
    localparam int W     = COL * PBW;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [3:0]   addr;
        logic [W-1:0] data;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   num_pass;
    logic         ofifo_o_valid;
    logic [W-1:0] ofifo_out;
    logic         ofifo_rd;
    logic         out_ready;
    logic         out_valid;
    logic [3:0]   out_addr;
    logic [W-1:0] out_data;
    logic         busy;
    logic         done;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] fifo_q[$];
    exp_t         exp_q[$];
    bit           gate_toggle = 0;
    bit           gate_phase = 0;
    bit           pop_pending = 0;
    int           rd_cnt = 0;
    int           cycle = 0;
    int           done_cnt = 0;
    int           last15_cycle = -10;
    bit           stall_at4 = 0;
    int           stall_cnt = 0;

    sfu_accum dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_pass      (num_pass),
        .ofifo_o_valid (ofifo_o_valid),
        .ofifo_out     (ofifo_out),
        .ofifo_rd      (ofifo_rd),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_addr      (out_addr),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] mk_row(input int base);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < COL; k++) r[k*PBW +: PBW] = 16'(base + k);
        return r;
    endfunction

    function automatic logic [W-1:0] mk_all(input logic [15:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < COL; k++) r[k*PBW +: PBW] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] mk_two(input logic [15:0] l0, input logic [15:0] l1);
        logic [W-1:0] r;
        r = '0;
        r[0 +: PBW]   = l0;
        r[PBW +: PBW] = l1;
        return r;
    endfunction

    // OFIFO model: head shown after each falling edge, popped after a rising edge that saw ofifo_rd.
    initial begin
        ofifo_o_valid = 1'b0;
        ofifo_out     = '0;
        forever begin
            @(negedge clk);
            if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
            gate_phase    = ~gate_phase;
            ofifo_o_valid = (fifo_q.size() > 0) && (!gate_toggle || gate_phase);
            ofifo_out     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            #4;
            pop_pending = ofifo_rd;
            if (ofifo_rd) begin
                rd_cnt++;
                chk("rd_needs_valid", W'(ofifo_o_valid), W'(1));
            end
        end
    end

    // Downstream ready: normally high, optionally stalled 3 cycles while address 4 is presented.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (stall_at4 && out_valid && out_addr == 4'd4 && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pop on each accepted write, hold check while stalled, done timing.
    initial begin
        bit           held;
        bit           prev_done;
        logic [3:0]   held_addr;
        logic [W-1:0] held_data;
        exp_t         e;
        held = 0;
        prev_done = 0;
        held_addr = '0;
        held_data = '0;
        forever begin
            @(negedge clk);
            #3;
            cycle++;
            if (done) begin
                done_cnt++;
                $display("job done at cycle %0d", cycle);
                chk("done_single_cycle", W'(prev_done), W'(0));
                chk("done_latency", W'(cycle), W'(last15_cycle + 1));
            end
            prev_done = done;
            if (held) begin
                chk("hold_addr", W'(out_addr), W'(held_addr));
                chk("hold_data", out_data, held_data);
            end
            held      = out_valid && !out_ready;
            held_addr = out_addr;
            held_data = out_data;
            if (out_valid && out_ready) begin
                $display("write addr=%0d data=%h", out_addr, out_data);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d, required no write", out_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_addr", W'(out_addr), W'(e.addr));
                    chk("out_data", out_data, e.data);
                end
                if (out_addr == 4'd15) last15_cycle = cycle;
            end
        end
    end

    task automatic pulse_start(input logic [3:0] np);
        @(negedge clk);
        num_pass = np;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        #4;
        chk("busy_after_start", W'(busy), W'(1));
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (done_cnt == d0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
        end else begin
            chk("busy_in_done", W'(busy), W'(1));
        end
        chk("scoreboard_empty", W'(exp_q.size()), W'(0));
        @(negedge clk);
        #4;
        chk("busy_idle", W'(busy), W'(0));
    endtask

    task automatic push_row(input logic [W-1:0] r);
        fifo_q.push_back(r);
    endtask

    task automatic push_exp(input int a, input logic [W-1:0] d);
        exp_t e;
        e.addr = 4'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        int rd0;
        int d0;
        int n;
        logic [W-1:0] exp_v;
        reset    = 1'b0;
        start    = 1'b0;
        num_pass = '0;
        repeat (3) @(negedge clk);
        #4;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_ofifo_rd", W'(ofifo_rd), W'(0));
        chk("rst_out_addr", W'(out_addr), W'(0));
        chk("rst_out_data", out_data, '0);
        @(negedge clk);
        reset = 1'b1;

        // Single pass: outputs equal the input rows.
        for (int a = 0; a < DEPTH; a++) begin
            push_row(mk_row(a * 8));
            push_exp(a, mk_row(a * 8));
        end
        pulse_start(4'd1);
        wait_done(200);

        // Three passes of 5 -> 15, exactly 48 pops.
        for (int i = 0; i < 3 * DEPTH; i++) push_row(mk_all(16'd5));
        for (int a = 0; a < DEPTH; a++) push_exp(a, mk_all(16'd15));
        rd0 = rd_cnt;
        pulse_start(4'd3);
        wait_done(300);
        chk("rd_count_3pass", W'(rd_cnt - rd0), W'(48));

        // Signed sums: lane0 -7+2, lane1 3+4.
        for (int i = 0; i < DEPTH; i++) push_row(mk_two(16'hFFF9, 16'd3));
        for (int i = 0; i < DEPTH; i++) push_row(mk_two(16'd2, 16'd4));
`ifdef SFU_RELU_EN
        exp_v = mk_two(16'h0000, 16'd7);
`else
        exp_v = mk_two(16'hFFFB, 16'd7);
`endif
        for (int a = 0; a < DEPTH; a++) push_exp(a, exp_v);
        pulse_start(4'd2);
        wait_done(300);

        // Overflow wraps: 7FFF + 7FFF = FFFE (negative, so ReLU clamps it).
        for (int i = 0; i < 2 * DEPTH; i++) push_row(mk_all(16'h7FFF));
`ifdef SFU_RELU_EN
        exp_v = mk_all(16'h0000);
`else
        exp_v = mk_all(16'hFFFE);
`endif
        for (int a = 0; a < DEPTH; a++) push_exp(a, exp_v);
        pulse_start(4'd2);
        wait_done(300);

        // Bursty OFIFO and a 3-cycle output stall at address 4.
        gate_toggle = 1;
        stall_at4   = 1;
        stall_cnt   = 0;
        for (int a = 0; a < DEPTH; a++) begin
            push_row(mk_row(1000 + a * 8));
            push_exp(a, mk_row(1000 + a * 8));
        end
        pulse_start(4'd1);
        wait_done(300);
        chk("stall_cycles", W'(stall_cnt), W'(3));
        gate_toggle = 0;
        stall_at4   = 0;

        // Reset during pass 1 at address 6, then a fresh single-pass job.
        for (int i = 0; i < DEPTH + 6; i++) push_row(mk_all(16'h1111));
        rd0 = rd_cnt;
        pulse_start(4'd2);
        n = 0;
        while ((rd_cnt - rd0) < DEPTH + 6 && n < 200) begin
            @(negedge clk);
            #5;
            n++;
        end
        chk("pops_before_reset", W'(rd_cnt - rd0), W'(DEPTH + 6));
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b0;
        #4;
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_ofifo_rd", W'(ofifo_rd), W'(0));
        chk("midrst_out_addr", W'(out_addr), W'(0));
        chk("midrst_out_data", out_data, '0);
        fifo_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #4;
        chk("no_done_on_reset", W'(done_cnt), W'(d0));
        for (int a = 0; a < DEPTH; a++) begin
            push_row(mk_row(16'h200 + a * 8));
            push_exp(a, mk_row(16'h200 + a * 8));
        end
        pulse_start(4'd1);
        repeat (3) @(negedge clk);
        pulse_start(4'd3);
        wait_done(300);
        repeat (3) @(negedge clk);
        #4;
        chk("no_restart_after_ignored_start", W'(busy), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sfu_accum.md
Name: sfu_accum

Overview:
- Special-function/accumulation stage directly downstream of the corelet.
- Pops psum vectors from the corelet output FIFO and accumulates them per output location over a programmed number of passes (kernel taps or input-channel tiles).
- After the last pass, drains each accumulated vector once through optional ReLU to the output-SRAM write port.

Parameters:
- col, 8, number of psum lanes per vector (matches mac_array columns)
- psum_bw, 16, signed width of each lane
- acc_depth, 16, number of output locations held in the accumulator buffer
- addr_bw, 4, address width, log2(acc_depth)
- pass_bw, 4, width of the pass-count field

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that launches a job; sampled only in IDLE
- num_pass  in  pass_bw  passes to accumulate; captured on start; 0 treated as 1
- ofifo_o_valid  in  1  corelet OFIFO has a complete row at its head
- ofifo_out  in  col*psum_bw  head row of OFIFO, valid while ofifo_o_valid
- ofifo_rd  out  1  pop request to OFIFO
- out_ready  in  1  downstream SRAM accepts a write this cycle
- out_valid  out  1  out_data/out_addr valid
- out_addr  out  addr_bw  output location index
- out_data  out  col*psum_bw  final vector, lane i at bits [i*psum_bw +: psum_bw]
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; all outputs 0; address and pass counters 0; accumulator contents don't-care.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 → ACCUM; latch num_pass (0→1); addr=0; pass=0.
  - start seen in any other state is ignored.
- ACCUM:
  - ofifo_rd = ofifo_o_valid (combinational). OFIFO presents its head combinationally and pops on the same edge.
  - On each pop: pass==0 writes acc[addr]=ofifo_out; otherwise acc[addr]=acc[addr]+ofifo_out, lane-wise signed, psum_bw-bit two's-complement wrap.
  - addr increments per pop. At addr==acc_depth-1 it wraps to 0 and pass increments.
  - The pop that completes pass num_pass-1 at addr acc_depth-1 moves the FSM to DRAIN with addr=0.
  - Gaps in ofifo_o_valid stall the FSM with no state change.
- DRAIN:
  - out_valid=1; out_addr=addr; out_data=f(acc[addr]), registered (data stable while out_valid and !out_ready).
  - Transfer occurs when out_valid && out_ready; addr then increments.
  - After transfer at addr acc_depth-1 → DONE.
  - ofifo_rd=0 in DRAIN, DONE and IDLE; OFIFO data arriving early waits in the OFIFO.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle FSM enters IDLE.
- Latency: out_valid first rises 1 cycle after the final pop. Throughput is 1 pop/cycle in ACCUM and 1 write/cycle in DRAIN with out_ready held high.
- Reset mid-job: immediate return to IDLE with no done pulse. Partial accumulations are discarded.
- Per-lane arithmetic: no cross-lane carry.

Optional Feature:
- Macro SFU_RELU_EN.
  - Defined: f(x) = x<0 ? 0 : x per lane at drain.
  - Undefined: f(x)=x, raw signed psums output.
- Accumulation is identical in both builds.

Decomposition:
- Package sfu_pkg: state enum (IDLE/ACCUM/DRAIN/DONE), lane-add and ReLU width constants.
- Sub-module sfu_lane_alu (one instance per lane): psum add and optional ReLU.
- FSM, counters and accumulator register array stay in sfu_accum.

Test Plan:
- num_pass=1, 16 rows with lane k of row a = a*8+k, out_ready=1 → 16 writes, out_addr 0..15, out_data equal to the input rows, done 1 cycle after write 15.
- num_pass=3, every lane = 5 each pass → all outputs 15; ofifo_rd count exactly 48; busy high from start+1 until done.
- SFU_RELU_EN defined, num_pass=2, lane0=-7 then +2, lane1=3 then 4 → lane0 out 0, lane1 out 7. Macro undefined → lane0 out -5.
- Overflow: num_pass=2, lane=16'h7FFF twice → 16'hFFFE without ReLU (wrap).
- ofifo_o_valid toggling 1/0 and out_ready low for 3 cycles at addr 4 → ofifo_rd never asserts without valid, out_data/out_addr held, no lost or duplicated writes.
- Reset pulled low mid-ACCUM (pass 1, addr 6), start re-issued with num_pass=1 → outputs 0 during reset, no done pulse, fresh job output matches only post-reset inputs. Start pulse while busy is ignored.
